// File: rtl/sdram_request_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port between NUM_PORTS requesters.
// Optional per-transaction watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_request_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        activeClock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_isWriting,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS*DATA_W-1:0] req_writeData,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_readData,
  output logic [ADDR_W-1:0]           ctrl_address,
  output logic [DATA_W-1:0]           ctrl_inputData,
  output logic                        ctrl_isWriting,
  output logic                        ctrl_inputValid,
  input  logic [DATA_W-1:0]           ctrl_outputData,
  input  logic                        ctrl_outputValid,
  input  logic                        ctrl_isBusy,
  input  logic                        ctrl_recievedCommand,
  output logic                        timeoutError
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_port;
  logic [PTR_W-1:0]   w_sel;
  logic [PTR_W-1:0]   w_cand;
  int                 w_idx;
  logic               w_found;
  logic               w_grant;
  logic               w_timeout;
  logic               w_active;
  logic               r_acc_cnt;
  logic               r_is_wr;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic [ADDR_W-1:0]  w_addr_arr [NUM_PORTS];
  logic [DATA_W-1:0]  w_data_arr [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign w_addr_arr[gi] = req_address[gi*ADDR_W +: ADDR_W];
      assign w_data_arr[gi] = req_writeData[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan from the port after the last winner, wrapping, so no port is served twice while others wait.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_idx  = (int'(r_rr_ptr) + k) % NUM_PORTS;
      w_cand = PTR_W'(w_idx);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_grant  = (r_state == S_IDLE) && w_found && !reset;
  assign w_active = (r_state == S_ISSUE) || (r_state == S_WAIT_ACCEPT) || (r_state == S_WAIT_DONE);

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [15:0] r_timer;
  logic        r_timeout_err;

  assign w_timeout    = w_active && (r_timer == 16'(TIMEOUT_CYCLES - 1));
  assign timeoutError = r_timeout_err;

  // Refresh stalls count toward the limit on purpose: a stuck refresh is also a fault.
  always_ff @(posedge activeClock) begin
    if (reset) begin
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_active)
        r_timer <= r_timer + 16'd1;
      else
        r_timer <= '0;
      if (w_timeout)
        r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_timeout    = 1'b0;
  assign timeoutError = 1'b0;
`endif

  always_ff @(posedge activeClock) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant)
          w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_timeout)
          w_state_next = S_RESPOND;
        else if (!ctrl_isBusy)
          w_state_next = ctrl_recievedCommand ? S_WAIT_DONE : S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        if (w_timeout)
          w_state_next = S_RESPOND;
        else if (ctrl_recievedCommand)
          w_state_next = S_WAIT_DONE;
        else if (r_acc_cnt)
          w_state_next = S_ISSUE;
      end
      S_WAIT_DONE: begin
        if (w_timeout)
          w_state_next = S_RESPOND;
        else if (r_is_wr ? !ctrl_isBusy : ctrl_outputValid)
          w_state_next = S_RESPOND;
      end
      S_RESPOND: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready       = '0;
    rsp_valid       = '0;
    ctrl_inputValid = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE:    if (w_found) req_ready[w_sel] = 1'b1;
        S_ISSUE:   ctrl_inputValid = !ctrl_isBusy;
        S_RESPOND: rsp_valid[r_port] = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge activeClock) begin
    if (reset) begin
      r_rr_ptr  <= PTR_W'(NUM_PORTS - 1);
      r_port    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_is_wr   <= 1'b0;
      r_rdata   <= '0;
      r_acc_cnt <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= w_sel;
        r_port   <= w_sel;
        r_addr   <= w_addr_arr[w_sel];
        r_wdata  <= w_data_arr[w_sel];
        r_is_wr  <= req_isWriting[w_sel];
      end
      r_acc_cnt <= (r_state == S_WAIT_ACCEPT) ? ~r_acc_cnt : 1'b0;
      if (w_timeout)
        r_rdata <= DATA_W'(16'hDEAD);
      else if ((r_state == S_WAIT_DONE) && !r_is_wr && ctrl_outputValid)
        r_rdata <= ctrl_outputData;
    end
  end

  assign rsp_readData   = r_rdata;
  assign ctrl_address   = r_addr;
  assign ctrl_inputData = r_wdata;
  assign ctrl_isWriting = r_is_wr;

endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Directed bench for sdram_request_arbiter with a small behavioural SDRAM controller model.
module tb_sdram_request_arbiter;
  localparam int NP = 4;
  localparam int AW = 25;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NP-1:0]    req_valid = '0;
  logic [NP-1:0]    req_isWriting = '0;
  logic [NP*AW-1:0] req_address = '0;
  logic [NP*DW-1:0] req_writeData = '0;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_readData;
  logic [AW-1:0]    ctrl_address;
  logic [DW-1:0]    ctrl_inputData;
  logic             ctrl_isWriting;
  logic             ctrl_inputValid;
  logic [DW-1:0]    ctrl_outputData;
  logic             ctrl_outputValid;
  logic             ctrl_isBusy;
  logic             ctrl_recievedCommand;
  logic             timeoutError;

  int checks = 0;
  int fails  = 0;

  // controller model state
  logic           refresh = 1'b0;
  logic           m_hang = 1'b0;
  logic           m_busy = 1'b0;
  logic           m_recv = 1'b0;
  logic           m_ov = 1'b0;
  logic           m_wr = 1'b0;
  logic [2:0]     m_cnt = '0;
  logic [7:0]     m_addr = '0;
  logic [DW-1:0]  m_od = '0;
  logic [DW-1:0]  mem [256];
  logic [255:0]   m_written = '0;

  always #5 clk = ~clk;

  sdram_request_arbiter dut (
    .activeClock          (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_isWriting        (req_isWriting),
    .req_address          (req_address),
    .req_writeData        (req_writeData),
    .req_ready            (req_ready),
    .rsp_valid            (rsp_valid),
    .rsp_readData         (rsp_readData),
    .ctrl_address         (ctrl_address),
    .ctrl_inputData       (ctrl_inputData),
    .ctrl_isWriting       (ctrl_isWriting),
    .ctrl_inputValid      (ctrl_inputValid),
    .ctrl_outputData      (ctrl_outputData),
    .ctrl_outputValid     (ctrl_outputValid),
    .ctrl_isBusy          (ctrl_isBusy),
    .ctrl_recievedCommand (ctrl_recievedCommand),
    .timeoutError         (timeoutError)
  );

  assign ctrl_isBusy          = m_busy | refresh;
  assign ctrl_recievedCommand = m_recv;
  assign ctrl_outputValid     = m_ov;
  assign ctrl_outputData      = m_ov ? m_od : '0;

  // Accepts a command, acks next cycle, stays busy 4 cycles; reads return data as busy drops.
  // Never-written locations read back as {8'hC0, addr[7:0]}.
  always @(posedge clk) begin
    m_recv <= 1'b0;
    m_ov   <= 1'b0;
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
    end else if (!m_busy) begin
      if (ctrl_inputValid) begin
        m_recv <= 1'b1;
        m_busy <= 1'b1;
        m_cnt  <= 3'd3;
        m_wr   <= ctrl_isWriting;
        m_addr <= ctrl_address[7:0];
        if (ctrl_isWriting) begin
          mem[ctrl_address[7:0]]       <= ctrl_inputData;
          m_written[ctrl_address[7:0]] <= 1'b1;
        end
      end
    end else if (m_cnt == 3'd0) begin
      m_busy <= 1'b0;
      if (!m_wr && !m_hang) begin
        m_ov <= 1'b1;
        m_od <= m_written[m_addr] ? mem[m_addr] : {8'hC0, m_addr};
      end
    end else begin
      m_cnt <= m_cnt - 3'd1;
    end
  end

  task automatic set_req(input int p, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_isWriting[p]         = wr;
    req_address[p*AW +: AW]  = a;
    req_writeData[p*DW +: DW] = d;
    req_valid[p]             = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at 1ns after the negedge where req_ready is seen; seen stays 0 on expiry.
  task automatic wait_ready(output logic [NP-1:0] seen, output int cyc);
    seen = '0;
    cyc  = 0;
    while (1) begin
      #1;
      if (req_ready != '0) begin
        seen = req_ready;
        break;
      end
      if (cyc >= 200) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_rsp(output logic [NP-1:0] seen, output int cyc, output logic busy_at);
    seen    = '0;
    cyc     = 0;
    busy_at = 1'bx;
    while (1) begin
      #1;
      if (rsp_valid != '0) begin
        seen    = rsp_valid;
        busy_at = ctrl_isBusy;
        break;
      end
      if (cyc >= 200) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, ctrl_inputValid, ctrl_isWriting} !== '0)
      $display("FAIL reset_ctl: got %b required 0", {req_ready, rsp_valid, ctrl_inputValid, ctrl_isWriting});
    checks++;
    if ({ctrl_address, ctrl_inputData, rsp_readData, timeoutError} !== '0)
      $display("FAIL reset_data: got addr %h data %h rd %h to %b required all 0",
               ctrl_address, ctrl_inputData, rsp_readData, timeoutError);
    fails += ({req_ready, rsp_valid, ctrl_inputValid, ctrl_isWriting} !== '0) ? 1 : 0;
    fails += ({ctrl_address, ctrl_inputData, rsp_readData, timeoutError} !== '0) ? 1 : 0;
    $display("reset: outputs checked");
    reset = 1'b0;
  endtask

  task automatic test_write_port1();
    logic [NP-1:0] seen;
    int cyc;
    logic busy_at;
    @(negedge clk);
    set_req(1, 1'b1, 25'h0012345, 16'hA5A5);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL t1_ready: got %b required 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (ctrl_inputValid !== 1'b1) begin
      fails++;
      $display("FAIL t1_inputValid: got %b required 1", ctrl_inputValid);
    end
    checks++;
    if (ctrl_address !== 25'h0012345 || ctrl_inputData !== 16'hA5A5 || ctrl_isWriting !== 1'b1) begin
      fails++;
      $display("FAIL t1_cmd: got addr %h data %h wr %b required 0012345 a5a5 1",
               ctrl_address, ctrl_inputData, ctrl_isWriting);
    end
    wait_rsp(seen, cyc, busy_at);
    checks++;
    if (seen !== 4'b0010) begin
      fails++;
      $display("FAIL t1_rsp: got %b required 0010", seen);
    end
    checks++;
    if (busy_at !== 1'b0) begin
      fails++;
      $display("FAIL t1_busy_at_rsp: got %b required 0", busy_at);
    end
    $display("write port1: rsp %b after %0d cycles", seen, cyc);
  endtask

  task automatic test_read_port2();
    logic [NP-1:0] seen;
    int cyc;
    logic busy_at;
    @(negedge clk);
    set_req(2, 1'b0, 25'h0012345, 16'h0000);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL t2_ready: got %b required 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(seen, cyc, busy_at);
    checks++;
    if (seen !== 4'b0100) begin
      fails++;
      $display("FAIL t2_rsp: got %b required 0100", seen);
    end
    checks++;
    if (rsp_readData !== 16'hA5A5) begin
      fails++;
      $display("FAIL t2_data: got %h required a5a5", rsp_readData);
    end
    $display("read port2: rsp %b data %h", seen, rsp_readData);
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] seen;
    logic [NP-1:0] rsp;
    logic [NP-1:0] prev;
    logic [NP-1:0] exp;
    logic [DW-1:0] exp_data;
    int cyc;
    logic busy_at;
    do_reset();
    for (int p = 0; p < NP; p++)
      set_req(p, 1'b0, 25'(32'h10 + p), 16'h0000);
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      exp      = NP'(1 << (i % NP));
      exp_data = 16'hC010 + 16'(i % NP);
      wait_ready(seen, cyc);
      checks++;
      if (seen !== exp) begin
        fails++;
        $display("FAIL rr_grant%0d: got %b required %b", i, seen, exp);
      end
      checks++;
      if (seen === prev) begin
        fails++;
        $display("FAIL rr_repeat%0d: got %b granted twice in a row", i, seen);
      end
      prev = seen;
      wait_rsp(rsp, cyc, busy_at);
      if (i == 5) req_valid = '0;
      checks++;
      if (rsp !== exp || rsp_readData !== exp_data) begin
        fails++;
        $display("FAIL rr_rsp%0d: got %b/%h required %b/%h", i, rsp, rsp_readData, exp, exp_data);
      end
      $display("round robin %0d: grant %b rsp %b data %h", i, seen, rsp, rsp_readData);
    end
  endtask

  task automatic test_refresh_stall();
    logic [NP-1:0] seen;
    int cyc;
    int viol;
    logic busy_at;
    @(negedge clk);
    set_req(3, 1'b0, 25'h0012345, 16'h0000);
    refresh = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL t4_ready: got %b required 1000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ctrl_inputValid !== 1'b0) viol++;
      @(negedge clk);
    end
    checks++;
    if (viol != 0) begin
      fails++;
      $display("FAIL t4_stall: inputValid high in %0d of 20 busy cycles, required 0", viol);
    end
    refresh = 1'b0;
    #1;
    checks++;
    if (ctrl_inputValid !== 1'b1 || ctrl_address !== 25'h0012345) begin
      fails++;
      $display("FAIL t4_issue: got valid %b addr %h required 1 0012345", ctrl_inputValid, ctrl_address);
    end
    wait_rsp(seen, cyc, busy_at);
    checks++;
    if (seen !== 4'b1000 || rsp_readData !== 16'hA5A5) begin
      fails++;
      $display("FAIL t4_rsp: got %b/%h required 1000/a5a5", seen, rsp_readData);
    end
    $display("refresh stall: rsp %b data %h", seen, rsp_readData);
  endtask

  task automatic test_reset_mid_read();
    logic [NP-1:0] seen;
    int cyc;
    int stray;
    logic busy_at;
    @(negedge clk);
    set_req(2, 1'b0, 25'h0012345, 16'h0000);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL t5_ready: got %b required 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    cyc = 0;
    while (cyc < 50) begin
      #1;
      if (m_recv) break;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 50) begin
      fails++;
      $display("FAIL t5_accept: command not accepted within %0d cycles", cyc);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, ctrl_inputValid, ctrl_isWriting} !== '0) begin
      fails++;
      $display("FAIL t5_reset_ctl: got %b required 0", {req_ready, rsp_valid, ctrl_inputValid, ctrl_isWriting});
    end
    checks++;
    if ({ctrl_address, ctrl_inputData, rsp_readData} !== '0) begin
      fails++;
      $display("FAIL t5_reset_data: got addr %h data %h rd %h required 0", ctrl_address, ctrl_inputData, rsp_readData);
    end
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== '0) stray++;
    end
    checks++;
    if (stray != 0) begin
      fails++;
      $display("FAIL t5_no_rsp: rsp_valid seen in %0d cycles after reset, required 0", stray);
    end
    @(negedge clk);
    set_req(0, 1'b1, 25'h0000777, 16'h1234);
    set_req(3, 1'b1, 25'h0000778, 16'h5678);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL t5_port0_ready: got %b required 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(seen, cyc, busy_at);
    checks++;
    if (seen !== 4'b0001) begin
      fails++;
      $display("FAIL t5_port0_rsp: got %b required 0001", seen);
    end
    $display("reset mid read: port0 rsp %b", seen);
  endtask

  task automatic test_timeout();
    logic [NP-1:0] seen;
    int cyc;
    logic busy_at;
`ifdef SDRAM_ARB_TIMEOUT_EN
    checks++;
    if (timeoutError !== 1'b0) begin
      fails++;
      $display("FAIL t6_pre: got timeoutError %b required 0", timeoutError);
    end
    m_hang = 1'b1;
    @(negedge clk);
    set_req(1, 1'b0, 25'h0012345, 16'h0000);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL t6_ready: got %b required 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(seen, cyc, busy_at);
    // 64 counted cycles in ISSUE..WAIT_DONE, RESPOND on the 65th cycle after the grant cycle
    checks++;
    if (cyc + 1 != 65) begin
      fails++;
      $display("FAIL t6_latency: got %0d cycles grant to rsp required 65", cyc + 1);
    end
    checks++;
    if (seen !== 4'b0010 || rsp_readData !== 16'hDEAD || timeoutError !== 1'b1) begin
      fails++;
      $display("FAIL t6_rsp: got %b/%h err %b required 0010/dead 1", seen, rsp_readData, timeoutError);
    end
    m_hang = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (timeoutError !== 1'b1) begin
      fails++;
      $display("FAIL t6_sticky: got %b required 1", timeoutError);
    end
    $display("timeout: rsp %b data %h err %b after %0d cycles", seen, rsp_readData, timeoutError, cyc + 1);
`else
    seen = '0;
    cyc = 0;
    busy_at = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (timeoutError !== 1'b0) begin
      fails++;
      $display("FAIL t6_tied: got timeoutError %b required 0", timeoutError);
    end
    $display("timeout disabled: timeoutError %b", timeoutError);
`endif
  endtask

  initial begin
    test_reset();
    test_write_port1();
    test_read_port2();
    test_round_robin();
    test_refresh_stall();
    test_reset_mid_read();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks %0d failures", checks, fails);
    $fatal(1, "time limit");
  end

endmodule
